// File: rtl/opb_register_bank_ppc2simulink.sv
// OPB slave register bank: C_NUM_REGS 32-bit registers exported to user logic,
// byte-enabled writes, single-cycle ack, optional self-clearing registers.
module opb_register_bank_ppc2simulink #(
  parameter logic [31:0]           C_BASEADDR     = 32'h0100C000,
  parameter logic [31:0]           C_HIGHADDR     = 32'h0100C0FF,
  parameter int                    C_NUM_REGS     = 4,
  parameter int                    C_OPB_AWIDTH   = 32,
  parameter int                    C_OPB_DWIDTH   = 32,
  parameter logic [C_NUM_REGS-1:0] C_AUTOCLR_MASK = '0,
  parameter string                 C_FAMILY       = "virtex6"
) (
  input  logic                      OPB_Clk,
  input  logic                      OPB_Rst,
  input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
  input  logic [0:3]                OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
  input  logic                      OPB_RNW,
  input  logic                      OPB_select,
  input  logic                      OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
  output logic                      Sl_xferAck,
  output logic                      Sl_errAck,
  output logic                      Sl_retry,
  output logic                      Sl_toutSup,
  output logic [32*C_NUM_REGS-1:0]  user_data_out,
  output logic [C_NUM_REGS-1:0]     user_wr_strb
);

  typedef enum logic [1:0] {IDLE, ACK, WAIT} state_t;

  localparam bit family_unused = (C_FAMILY != "");
  logic seq_unused;
  assign seq_unused = OPB_seqAddr;

  state_t                  state_q;
  logic [31:0]             regs_q [C_NUM_REGS];
  logic [31:0]             dbus_q;
  logic                    ack_q;
  logic [C_NUM_REGS-1:0]   strb_q;

  logic [31:0]             addr;
  logic [31:0]             wdata;
  logic [31:0]             word_idx;
  logic                    hit;
  logic                    in_bank;
  logic [31:0]             rd_data_d;

  // Bus is big-endian: bit 0 is the MSB, so a plain assignment gives DBus[i] <-> bit 31-i.
  assign addr     = OPB_ABus;
  assign wdata    = OPB_DBus;
  assign hit      = OPB_select && (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
  assign word_idx = (addr - C_BASEADDR) >> 2;
  assign in_bank  = word_idx < 32'(C_NUM_REGS);

  always_comb begin
    rd_data_d = '0;
    for (int k = 0; k < C_NUM_REGS; k++) begin
      if (word_idx == 32'(k)) rd_data_d = regs_q[k];
    end
  end

  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      dbus_q  <= '0;
      strb_q  <= '0;
      for (int k = 0; k < C_NUM_REGS; k++) regs_q[k] <= '0;
    end else begin
      ack_q  <= 1'b0;
      dbus_q <= '0;
      strb_q <= '0;
      case (state_q)
        IDLE: begin
          if (hit) begin
            state_q <= ACK;
            ack_q   <= 1'b1;
            if (OPB_RNW) begin
              dbus_q <= rd_data_d;
            end else if (in_bank) begin
              for (int k = 0; k < C_NUM_REGS; k++) begin
                if (word_idx == 32'(k)) begin
                  strb_q[k] <= |OPB_BE;
                  for (int b = 0; b < 4; b++) begin
                    if (OPB_BE[b]) regs_q[k][31-8*b -: 8] <= wdata[31-8*b -: 8];
                  end
                end
              end
            end
          end
        end
        ACK: begin
          state_q <= WAIT;
          // Self-clearing registers give user logic a one-cycle pulse.
          for (int k = 0; k < C_NUM_REGS; k++) begin
            if (C_AUTOCLR_MASK[k]) regs_q[k] <= '0;
          end
        end
        WAIT: begin
          if (!OPB_select) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < C_NUM_REGS; k++) begin : g_out
    assign user_data_out[32*k +: 32] = regs_q[k];
  end

  assign Sl_DBus      = dbus_q;
  assign Sl_xferAck   = ack_q;
  assign user_wr_strb = strb_q;
  assign Sl_errAck    = 1'b0;
  assign Sl_retry     = 1'b0;
  assign Sl_toutSup   = 1'b0;

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// Bench for the OPB register bank: transaction-level model of the register file
// checked against the DUT every cycle, plus directed literal scenarios.
module tb_opb_register_bank_ppc2simulink;

  localparam logic [31:0] BASE = 32'h0100C000;
  localparam logic [31:0] HIGH = 32'h0100C0FF;
  localparam int          NR   = 4;
  localparam logic [3:0]  ACLR = 4'b0001;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [0:31]  abus = '0;
  logic [0:3]   be = '0;
  logic [0:31]  dbus = '0;
  logic         rnw = 1'b0;
  logic         sel = 1'b0;
  logic         seq = 1'b0;
  logic [0:31]  sl_dbus;
  logic         sl_ack, sl_err, sl_retry, sl_tout;
  logic [127:0] udo;
  logic [3:0]   strb;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0]  model [NR];
  bit           chk_en = 1'b0;
  bit           exp_ack;
  logic [31:0]  exp_dbus;
  logic [3:0]   exp_strb;
  int           ack_cnt = 0;
  int           strb_cnt = 0;
  logic [31:0]  last_rd;
  logic [127:0] last_udo;

  always #5 clk = ~clk;

  opb_register_bank_ppc2simulink #(
    .C_BASEADDR(BASE), .C_HIGHADDR(HIGH), .C_NUM_REGS(NR), .C_AUTOCLR_MASK(ACLR)
  ) dut (
    .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus),
    .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seq), .Sl_DBus(sl_dbus),
    .Sl_xferAck(sl_ack), .Sl_errAck(sl_err), .Sl_retry(sl_retry), .Sl_toutSup(sl_tout),
    .user_data_out(udo), .user_wr_strb(strb)
  );

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  function automatic logic [127:0] model_flat();
    logic [127:0] f;
    for (int k = 0; k < NR; k++) f[32*k +: 32] = model[k];
    return f;
  endfunction

  // Compare process: outputs settle after the rising edge, sampled on the falling edge.
  always @(negedge clk) begin
    if (sl_ack) begin
      ack_cnt++;
      last_rd  = sl_dbus;
      last_udo = udo;
    end
    if (strb != 4'b0) strb_cnt++;
    if (chk_en) begin
      check("xferAck", 128'(sl_ack), 128'(exp_ack));
      check("Sl_DBus", 128'(sl_dbus), 128'(exp_dbus));
      check("wr_strb", 128'(strb), 128'(exp_strb));
      check("user_data_out", udo, model_flat());
      check("tied_zero", 128'({sl_err, sl_retry, sl_tout}), 128'(0));
    end
  end

  task automatic set_idle_exp();
    exp_ack  = 1'b0;
    exp_dbus = '0;
    exp_strb = '0;
  endtask

  // One bus transfer: select held for 'hold' sampling edges, then 'gap' idle edges.
  // Called and returns at 1 time unit after a rising edge.
  task automatic do_xfer(input logic [31:0] a, input bit rd, input logic [0:3] b,
                         input logic [31:0] d, input int hold, input int gap);
    bit          is_hit;
    int          idx;
    logic [31:0] m;
    is_hit = (a >= BASE) && (a <= HIGH);
    idx    = int'((a - BASE) >> 2);
    abus = a; rnw = rd; be = b; dbus = d; sel = 1'b1;
    for (int c = 0; c < hold + gap; c++) begin
      @(posedge clk); #1;
      set_idle_exp();
      if (c == 0 && is_hit) begin
        exp_ack = 1'b1;
        if (rd) begin
          if (idx < NR) exp_dbus = model[idx];
        end else if (idx < NR) begin
          m = model[idx];
          for (int j = 0; j < 4; j++) if (b[j]) m[31-8*j -: 8] = d[31-8*j -: 8];
          model[idx] = m;
          if (b != 4'b0) exp_strb[idx] = 1'b1;
        end
      end
      if (c == 1 && is_hit) begin
        for (int k = 0; k < NR; k++) if (ACLR[k]) model[k] = '0;
      end
      if (c == hold - 1) begin
        sel = 1'b0;
        abus = $urandom; dbus = $urandom; be = 4'($urandom); rnw = 1'($urandom);
      end
    end
  endtask

  initial begin
    int a0, s0, r, hold;
    logic [31:0] a;
    logic [127:0] snap;
    for (int k = 0; k < NR; k++) model[k] = '0;
    set_idle_exp();

    // Reset state, including an edge while reset is held
    @(negedge clk);
    check("rst_ack", 128'(sl_ack), 128'(0));
    check("rst_udo", udo, 128'(0));
    check("rst_dbus", 128'(sl_dbus), 128'(0));
    check("rst_strb", 128'(strb), 128'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    chk_en = 1'b1;

    // Full write to BASE+4
    a0 = ack_cnt; s0 = strb_cnt;
    do_xfer(BASE + 4, 1'b0, 4'b1111, 32'hDEADBEEF, 2, 2);
    check("w1_udo", 128'(udo[63:32]), 128'(32'hDEADBEEF));
    check("w1_ack_count", 128'(ack_cnt - a0), 128'(1));
    check("w1_strb_count", 128'(strb_cnt - s0), 128'(1));

    // Partial write merges bytes 1 and 3, then read back
    do_xfer(BASE + 4, 1'b0, 4'b0101, 32'h11223344, 1, 2);
    check("merge_udo", 128'(udo[63:32]), 128'(32'hDE22BE44));
    check("merge_model", 128'(model[1]), 128'(32'hDE22BE44));
    do_xfer(BASE + 4, 1'b1, 4'b1111, 32'h0, 2, 2);
    check("merge_read", 128'(last_rd), 128'(32'hDE22BE44));

    // Self-clearing register 0
    do_xfer(BASE, 1'b0, 4'b1111, 32'h1, 1, 2);
    check("aclr_pulse", 128'(last_udo[31:0]), 128'(1));
    check("aclr_after", 128'(udo[31:0]), 128'(0));
    do_xfer(BASE, 1'b1, 4'b1111, 32'h0, 1, 2);
    check("aclr_read", 128'(last_rd), 128'(0));

    // Index 8: in address range but beyond the bank
    a0 = ack_cnt; s0 = strb_cnt; snap = udo;
    do_xfer(BASE + 32, 1'b1, 4'b1111, 32'h0, 1, 2);
    check("oob_read_ack", 128'(ack_cnt - a0), 128'(1));
    check("oob_read_data", 128'(last_rd), 128'(0));
    do_xfer(BASE + 32, 1'b0, 4'b1111, 32'hCAFEF00D, 1, 2);
    check("oob_write_strb", 128'(strb_cnt - s0), 128'(0));
    check("oob_write_udo", udo, snap);

    // Non-hit address: no ack at all
    a0 = ack_cnt;
    do_xfer(HIGH + 1, 1'b1, 4'b1111, 32'h0, 3, 2);
    check("miss_ack", 128'(ack_cnt - a0), 128'(0));

    // Select held 5 cycles gives a single ack and strobe
    a0 = ack_cnt; s0 = strb_cnt;
    do_xfer(BASE + 12, 1'b0, 4'b1111, 32'h0BADF00D, 5, 2);
    check("hold5_ack", 128'(ack_cnt - a0), 128'(1));
    check("hold5_strb", 128'(strb_cnt - s0), 128'(1));
    check("hold5_udo", 128'(udo[127:96]), 128'(32'h0BADF00D));

    // Randomized transfers
    for (int t = 0; t < 80; t++) begin
      r = $urandom_range(0, 9);
      if (r <= 6)      a = BASE + 32'($urandom_range(0, 15));
      else if (r == 7) a = BASE + 32'($urandom_range(16, 255));
      else if (r == 8) a = BASE - 32'($urandom_range(1, 256));
      else             a = HIGH + 32'($urandom_range(1, 1000));
      hold = $urandom_range(1, 5);
      do_xfer(a, 1'($urandom), 4'($urandom), $urandom, hold, $urandom_range(2, 3));
    end

    // Reset asserted during the ACK cycle of a write, select kept high
    chk_en = 1'b0;
    abus = BASE + 8; rnw = 1'b0; be = 4'b1111; dbus = 32'hDEADBEEF; sel = 1'b1;
    @(posedge clk); #1;
    check("rstack_pre_ack", 128'(sl_ack), 128'(1));
    rst = 1'b1;
    #1;
    check("rstack_ack", 128'(sl_ack), 128'(0));
    check("rstack_udo", udo, 128'(0));
    check("rstack_strb", 128'(strb), 128'(0));
    check("rstack_dbus", 128'(sl_dbus), 128'(0));
    @(posedge clk); #1;
    check("rstack_held_ack", 128'(sl_ack), 128'(0));
    rst = 1'b0;
    @(posedge clk); #1;
    check("rstack_reissue_ack", 128'(sl_ack), 128'(1));
    check("rstack_reissue_udo", 128'(udo[95:64]), 128'(32'hDEADBEEF));
    sel = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int k = 0; k < NR; k++) model[k] = '0;
    model[2] = 32'hDEADBEEF;
    set_idle_exp();
    chk_en = 1'b1;
    do_xfer(BASE + 8, 1'b1, 4'b1111, 32'h0, 2, 2);
    check("post_rst_read", 128'(last_rd), 128'(32'hDEADBEEF));

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
